// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/RAM type definitions
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and RAM-port bundle for ram_arbiter
interface ram_arbiter_if #(
    parameter int NREQ = 4
);

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        wen;
    logic [NREQ-1:0]        blk;
    logic [NREQ-1:0][31:0]  addr;
    logic [NREQ-1:0][31:0]  wdata;
    logic [NREQ-1:0]        rwait;
    logic [NREQ-1:0]        grant;
    logic                   rbeat;
    logic [31:0]            rdata;
    logic                   ramREN;
    logic                   ramWEN;
    logic [31:0]            ramaddr;
    logic [31:0]            ramstore;
    logic [31:0]            ramload;
    cpu_types_pkg::ramstate_t ramstate;

    modport master (
        output req, wen, blk, addr, wdata, ramload, ramstate,
        input  rwait, grant, rbeat, rdata, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        input  req, wen, blk, addr, wdata, ramload, ramstate,
        output rwait, grant, rbeat, rdata, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one RAM port between NREQ requesters
module ram_arbiter #(
    parameter int NREQ = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    ram_arbiter_if.slave  bus
);

    import cpu_types_pkg::*;

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;

    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    logic [1:0]    state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last;
    logic [IW-1:0] winner;
    logic [IW-1:0] idx;
    logic          any_req;
    logic          active;
    logic          live;
    logic          done;
    logic [31:0]   base;

    // Search begins just past the previous owner so it ranks last next round.
    always_comb begin
        winner  = last;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last) + i) % NREQ);
            if (!any_req && bus.req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    always_comb begin
        active = (state == BEAT0) || (state == BEAT1);
        live   = active && bus.req[owner];
        done   = live && (bus.ramstate == ACCESS);
        base   = {bus.addr[owner][31:2], 2'b00};
    end

    assign bus.rdata = bus.ramload;

    // A dropped owner request kills the RAM enables in the same cycle.
    always_comb begin
        bus.grant    = '0;
        bus.rwait    = '1;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'h0;
        bus.ramstore = 32'h0;
        bus.rbeat    = (state == BEAT1);
        if (active) begin
            bus.grant[owner] = 1'b1;
            bus.ramaddr      = (state == BEAT1) ? base + 32'd4 : base;
            bus.ramstore     = bus.wdata[owner];
        end
        if (live) begin
            bus.ramREN = ~bus.wen[owner];
            bus.ramWEN = bus.wen[owner];
        end
        if (done) begin
            bus.rwait[owner] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            owner <= '0;
            last  <= LAST_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= winner;
                        state <= BEAT0;
                    end
                end
                BEAT0: begin
                    if (!bus.req[owner]) begin
                        state <= IDLE;
                        last  <= owner;
                    end else if (done) begin
                        if (bus.blk[owner]) begin
                            state <= BEAT1;
                        end else begin
                            state <= IDLE;
                            last  <= owner;
                        end
                    end
                end
                BEAT1: begin
                    if (!bus.req[owner] || done) begin
                        state <= IDLE;
                        last  <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter
module tb_ram_arbiter;

    import cpu_types_pkg::*;

    localparam int NREQ = 4;

    typedef struct {
        int          id;
        logic        beat;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        fin;
        logic        consec;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST;

    ram_arbiter_if #(.NREQ(NREQ)) bus ();

    ram_arbiter #(.NREQ(NREQ)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    exp_t        q[$];
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          last_done_cyc = 0;
    int          ren_cycles = 0;
    int          tgt;
    logic        gap_pending = 1'b0;
    int          n_xfer[NREQ];
    logic [31:0] wd0[NREQ];
    logic [31:0] wd1[NREQ];
    ramstate_t   stall_st;
    int          ram_lat = 0;
    int          ram_cnt = 0;
    logic [31:0] ram_rd;

    assign bus.ramload = ram_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] r, input logic we, input logic b,
                         input logic [31:0] a, input logic [31:0] d0,
                         input logic [31:0] d1, input int nx);
        bus.wen[r]   = we;
        bus.blk[r]   = b;
        bus.addr[r]  = a;
        bus.wdata[r] = d0;
        wd0[r]       = d0;
        wd1[r]       = d1;
        n_xfer[r]    = nx;
        bus.req[r]   = 1'b1;
    endtask

    task automatic expect_xfer(input logic [1:0] r);
        exp_t e;
        e.id     = int'(r);
        e.beat   = 1'b0;
        e.we     = bus.wen[r];
        e.addr   = {bus.addr[r][31:2], 2'b00};
        e.data   = e.we ? wd0[r] : ram_rd;
        e.fin    = !bus.blk[r];
        e.consec = 1'b0;
        q.push_back(e);
        if (bus.blk[r]) begin
            e.beat   = 1'b1;
            e.addr   = e.addr + 32'd4;
            e.data   = e.we ? wd1[r] : ram_rd;
            e.fin    = 1'b1;
            e.consec = 1'b1;
            q.push_back(e);
        end
    endtask

    // One clock: observe at negedge, update requesters and RAM model after posedge.
    task automatic tick();
        logic [NREQ-1:0] fin_set;
        logic [NREQ-1:0] mid_set;
        exp_t e;
        fin_set = '0;
        mid_set = '0;
        @(negedge CLK);
        cyc++;
        if (bus.ramREN) ren_cycles++;
        chk("ren_wen_excl", 32'(bus.ramREN & bus.ramWEN), 32'h0);
        if (gap_pending) begin
            chk("idle_gap_grant", 32'(bus.grant), 32'h0);
            gap_pending = 1'b0;
        end
        for (int r = 0; r < NREQ; r++) begin
            if (!bus.rwait[2'(r)]) begin
                chk("pulse_expected", 32'(q.size() > 0), 32'h1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("pulse_id", 32'(r), 32'(e.id));
                    chk("grant", 32'(bus.grant), 32'(1 << e.id));
                    chk("rbeat", 32'(bus.rbeat), 32'(e.beat));
                    chk("ramaddr", bus.ramaddr, e.addr);
                    if (e.we) begin
                        chk("ramWEN", 32'(bus.ramWEN), 32'h1);
                        chk("ramstore", bus.ramstore, e.data);
                    end else begin
                        chk("ramREN", 32'(bus.ramREN), 32'h1);
                        chk("rdata", bus.rdata, e.data);
                    end
                    if (e.consec) chk("consecutive_beats", 32'(cyc - last_done_cyc), 32'h1);
                    last_done_cyc = cyc;
                    done_cnt++;
                    if (e.fin) begin
                        fin_set[r]  = 1'b1;
                        gap_pending = 1'b1;
                    end else begin
                        mid_set[r] = 1'b1;
                    end
                end
            end
        end
        @(posedge CLK);
        #1;
        for (int r = 0; r < NREQ; r++) begin
            if (fin_set[r]) begin
                n_xfer[r]--;
                if (n_xfer[r] <= 0) bus.req[2'(r)] = 1'b0;
                else bus.wdata[2'(r)] = wd0[r];
            end
            if (mid_set[r]) bus.wdata[2'(r)] = wd1[r];
        end
        #1;
        if (bus.ramREN || bus.ramWEN) begin
            if (ram_cnt < ram_lat) begin
                bus.ramstate = stall_st;
                ram_cnt++;
            end else begin
                bus.ramstate = ACCESS;
                ram_cnt = 0;
            end
        end else begin
            bus.ramstate = FREE;
            ram_cnt = 0;
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk("done_within_budget", 32'(done_cnt >= target), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        bus.req      = '0;
        bus.wen      = '0;
        bus.blk      = '0;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.ramstate = FREE;
        stall_st     = BUSY;
        ram_rd       = 32'h5A5A_0001;
        for (int r = 0; r < NREQ; r++) begin
            n_xfer[r] = 0;
            wd0[r]    = 32'h0;
            wd1[r]    = 32'h0;
        end
        nRST = 1'b0;

        // Reset held with every requester asking; then fairness sweep 0,1,2,3,0.
        issue(2'd0, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 2);
        issue(2'd1, 1'b0, 1'b0, 32'h0000_1010, 32'h0, 32'h0, 1);
        issue(2'd2, 1'b0, 1'b0, 32'h0000_1020, 32'h0, 32'h0, 1);
        issue(2'd3, 1'b0, 1'b0, 32'h0000_1030, 32'h0, 32'h0, 1);
        repeat (2) tick();
        #1;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_rwait", 32'(bus.rwait), 32'hF);
        chk("rst_ramREN", 32'(bus.ramREN), 32'h0);
        chk("rst_ramWEN", 32'(bus.ramWEN), 32'h0);
        chk("rst_ramaddr", bus.ramaddr, 32'h0);
        chk("rst_rbeat", 32'(bus.rbeat), 32'h0);
        expect_xfer(2'd0);
        expect_xfer(2'd1);
        expect_xfer(2'd2);
        expect_xfer(2'd3);
        expect_xfer(2'd0);
        tgt  = done_cnt + 5;
        nRST = 1'b1;
        tick();
        #1;
        chk("first_grant", 32'(bus.grant), 32'h1);
        wait_done(tgt, 40);
        repeat (2) tick();

        // Single read with two BUSY cycles.
        ram_rd     = 32'hDEAD_BEEF;
        ram_lat    = 2;
        stall_st   = BUSY;
        ren_cycles = 0;
        issue(2'd2, 1'b0, 1'b0, 32'h0000_0103, 32'h0, 32'h0, 1);
        expect_xfer(2'd2);
        tgt = done_cnt + 1;
        tick();
        #1;
        chk("read_ramaddr", bus.ramaddr, 32'h0000_0100);
        wait_done(tgt, 20);
        repeat (2) tick();
        chk("read_ren_cycles", 32'(ren_cycles), 32'd3);

        // Block write wrapping past the top of the address space.
        ram_lat = 0;
        issue(2'd1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h11, 32'h22, 1);
        expect_xfer(2'd1);
        tgt = done_cnt + 2;
        tick();
        #1;
        chk("blk_b0_ramaddr", bus.ramaddr, 32'hFFFF_FFFC);
        chk("blk_b0_ramstore", bus.ramstore, 32'h11);
        wait_done(tgt, 20);
        repeat (2) tick();

        // Abort in BEAT1 before ACCESS, then 0 beats 2 after last=3.
        ram_lat  = 2;
        stall_st = BUSY;
        issue(2'd3, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 32'h0, 1);
        expect_xfer(2'd3);
        void'(q.pop_back());
        tgt = done_cnt + 1;
        wait_done(tgt, 20);
        #1;
        chk("abort_in_beat1", 32'(bus.rbeat), 32'h1);
        chk("abort_pre_ramREN", 32'(bus.ramREN), 32'h1);
        bus.req[3] = 1'b0;
        #1;
        chk("abort_ramREN", 32'(bus.ramREN), 32'h0);
        chk("abort_ramWEN", 32'(bus.ramWEN), 32'h0);
        chk("abort_rwait", 32'(bus.rwait), 32'hF);
        tick();
        #1;
        chk("abort_idle_grant", 32'(bus.grant), 32'h0);
        ram_lat = 0;
        ram_rd  = 32'h0BAD_F00D;
        issue(2'd0, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h0, 1);
        issue(2'd2, 1'b0, 1'b0, 32'h0000_0310, 32'h0, 32'h0, 1);
        expect_xfer(2'd0);
        expect_xfer(2'd2);
        tgt = done_cnt + 2;
        wait_done(tgt, 20);
        repeat (2) tick();

        // ERROR stalls for three cycles then ACCESS.
        ram_lat  = 3;
        stall_st = ERROR;
        ram_rd   = 32'hCAFE_0123;
        issue(2'd1, 1'b0, 1'b0, 32'h0000_0344, 32'h0, 32'h0, 1);
        expect_xfer(2'd1);
        tgt = done_cnt + 1;
        tick();
        repeat (3) begin
            #1;
            chk("err_ramREN_held", 32'(bus.ramREN), 32'h1);
            chk("err_ramaddr_held", bus.ramaddr, 32'h0000_0344);
            chk("err_rwait_high", 32'(bus.rwait), 32'hF);
            tick();
        end
        wait_done(tgt, 10);
        repeat (2) tick();

        // Asynchronous reset in the middle of a transfer.
        ram_lat  = 5;
        stall_st = BUSY;
        issue(2'd2, 1'b0, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 1);
        tick();
        tick();
        #1;
        chk("midrst_pre_grant", 32'(bus.grant), 32'h4);
        nRST = 1'b0;
        #1;
        chk("midrst_grant", 32'(bus.grant), 32'h0);
        chk("midrst_ramREN", 32'(bus.ramREN), 32'h0);
        chk("midrst_rwait", 32'(bus.rwait), 32'hF);
        bus.req = '0;
        repeat (2) tick();
        nRST = 1'b1;
        repeat (2) tick();
        #1;
        chk("post_rst_grant", 32'(bus.grant), 32'h0);
        chk("scoreboard_empty", 32'(q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
